// File: rtl/svc_rv_dcache_axi_port_pkg.sv
// Shared constants and FSM state type for the RV data-cache AXI4 master port.
// Holds AXI burst/response encodings and a line-offset helper.
package svc_rv_dcache_axi_port_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_WR_RESP
  } state_t;

  // Number of byte-offset bits inside one cache line / AXI beat.
  function automatic int line_offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/svc_rv_dcache_axi_port.sv
// Downstream AXI4 master of the RV data cache: one line fill or writeback at a time,
// each mapped onto a single-beat INCR transaction.
module svc_rv_dcache_axi_port
  import svc_rv_dcache_axi_port_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        fill_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   fill_addr,
  output logic                        fill_ready,
  output logic                        fill_done,
  output logic [AXI_DATA_WIDTH-1:0]   fill_data,

  input  logic                        wb_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   wb_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   wb_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] wb_strb,
  output logic                        wb_ready,
  output logic                        wb_done,

  output logic                        err,

  output logic                        m_axi_arvalid,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  input  logic                        m_axi_arready,

  input  logic                        m_axi_rvalid,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  output logic                        m_axi_rready,

  output logic                        m_axi_awvalid,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  input  logic                        m_axi_awready,

  output logic                        m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  input  logic                        m_axi_wready,

  input  logic                        m_axi_bvalid,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_bready
);

  localparam int OFFSET_BITS = line_offset_bits(AXI_DATA_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK =
    ~AXI_ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic                        r_aw_sent;
  logic                        r_w_sent;
  logic                        r_fill_done;
  logic                        r_wb_done;
  logic                        r_err;
  logic [AXI_DATA_WIDTH-1:0]   r_fill_data;
  logic                        w_unused;

  assign m_axi_arid    = AXI_ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(OFFSET_BITS);
  assign m_axi_arburst = BURST_INCR;

  assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(OFFSET_BITS);
  assign m_axi_awburst = BURST_INCR;

  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = 1'b1;

  assign fill_done     = r_fill_done;
  assign fill_data     = r_fill_data;
  assign wb_done       = r_wb_done;
  assign err           = r_err;

  // Every transaction is a single beat, so rlast and the returned IDs carry no extra information.
  assign w_unused = ^{m_axi_rlast, m_axi_rid, m_axi_bid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    fill_ready    = 1'b0;
    wb_ready      = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        fill_ready = !rst;
        wb_ready   = !rst;
        // A pending writeback goes first so a following fill sees the written line.
        if (wb_valid) begin
          w_state_next = ST_WR;
        end else if (fill_valid) begin
          w_state_next = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          w_state_next = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WR: begin
        m_axi_awvalid = !r_aw_sent;
        m_axi_wvalid  = !r_w_sent;
        if ((r_aw_sent || m_axi_awready) && (r_w_sent || m_axi_wready)) begin
          w_state_next = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_sent   <= 1'b0;
      r_w_sent    <= 1'b0;
      r_fill_done <= 1'b0;
      r_wb_done   <= 1'b0;
      r_err       <= 1'b0;
      r_fill_data <= '0;
    end else begin
      r_fill_done <= 1'b0;
      r_wb_done   <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wb_valid) begin
            r_addr    <= wb_addr & LINE_MASK;
            r_wdata   <= wb_data;
            r_wstrb   <= wb_strb;
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
          end else if (fill_valid) begin
            r_addr <= fill_addr & LINE_MASK;
          end
        end
        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_fill_data <= m_axi_rdata;
            r_fill_done <= 1'b1;
            r_err       <= (m_axi_rresp != RESP_OKAY);
          end
        end
        ST_WR: begin
          if (m_axi_awvalid && m_axi_awready) begin
            r_aw_sent <= 1'b1;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            r_w_sent <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_wb_done <= 1'b1;
            r_err     <= (m_axi_bresp != RESP_OKAY);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FORMAL
  // IDs are never compared in logic; a slave returning a foreign ID is caught here only.
  assert property (@(posedge clk) disable iff (rst)
    (m_axi_rvalid && m_axi_rready) |-> (m_axi_rid == AXI_ID_WIDTH'(AXI_ID)));
  assert property (@(posedge clk) disable iff (rst)
    (m_axi_bvalid && m_axi_bready) |-> (m_axi_bid == AXI_ID_WIDTH'(AXI_ID)));
`endif

endmodule

// File: tb/tb_svc_rv_dcache_axi_port.sv
// Bench for svc_rv_dcache_axi_port: AXI slave model with programmable stalls plus a
// scoreboard of expected fill/writeback completions.
module tb_svc_rv_dcache_axi_port;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          fill_valid = 1'b0;
  logic [31:0]   fill_addr = '0;
  logic          fill_ready;
  logic          fill_done;
  logic [127:0]  fill_data;
  logic          wb_valid = 1'b0;
  logic [31:0]   wb_addr = '0;
  logic [127:0]  wb_data = '0;
  logic [15:0]   wb_strb = '0;
  logic          wb_ready;
  logic          wb_done;
  logic          err;

  logic          m_axi_arvalid;
  logic [3:0]    m_axi_arid;
  logic [31:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arready = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic [3:0]    m_axi_rid = '0;
  logic [127:0]  m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rlast = 1'b0;
  logic          m_axi_rready;
  logic          m_axi_awvalid;
  logic [3:0]    m_axi_awid;
  logic [31:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awready = 1'b0;
  logic          m_axi_wvalid;
  logic [127:0]  m_axi_wdata;
  logic [15:0]   m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wready = 1'b0;
  logic          m_axi_bvalid = 1'b0;
  logic [3:0]    m_axi_bid = '0;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bready;

  svc_rv_dcache_axi_port dut (
    .clk(clk), .rst(rst),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_ready(fill_ready),
    .fill_done(fill_done), .fill_data(fill_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_strb(wb_strb),
    .wb_ready(wb_ready), .wb_done(wb_done), .err(err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- AXI slave model ----------------
  logic [127:0] mem [0:1023];
  int   ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;
  logic rresp_err = 1'b0;
  int   ar_cnt, r_cnt, aw_cnt, w_cnt;
  bit   ar_hs, r_hs, aw_hs, w_hs, b_hs;
  bit   rd_pend, aw_got, w_got, aw_stalling;
  logic [31:0]  rd_addr, wr_addr, aw_first;
  logic [127:0] wr_data, line_tmp;
  logic [15:0]  wr_strb;
  int   ar_count = 0, aw_count = 0, w_count = 0, b_count = 0;
  int   awv_cycles = 0, wv_cycles = 0, stab_err = 0;
  logic [31:0]  last_araddr, last_awaddr;
  logic [7:0]   last_arlen, last_awlen;
  logic [2:0]   last_arsize, last_awsize;
  logic [1:0]   last_arburst, last_awburst;
  logic [15:0]  last_wstrb;
  logic         last_wlast;

  always @(negedge clk) begin
    if (rst) begin
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
      m_axi_bvalid = 0; ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      rd_pend = 0; aw_got = 0; w_got = 0; aw_stalling = 0;
    end else begin
      // retire handshakes completed on the preceding rising edge
      if (ar_hs) begin rd_pend = 1; rd_addr = last_araddr; r_cnt = 0; end
      if (r_hs) begin m_axi_rvalid = 0; rd_pend = 0; end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (b_hs) m_axi_bvalid = 0;
      if (aw_got && w_got) begin
        line_tmp = mem[wr_addr[13:4]];
        for (int b = 0; b < 16; b++)
          if (wr_strb[b]) line_tmp[b*8 +: 8] = wr_data[b*8 +: 8];
        mem[wr_addr[13:4]] = line_tmp;
        aw_got = 0; w_got = 0;
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
      end
      if (rd_pend && !m_axi_rvalid) begin
        if (r_cnt >= r_delay) begin
          m_axi_rvalid = 1; m_axi_rdata = mem[rd_addr[13:4]];
          m_axi_rresp = rresp_err ? 2'b10 : 2'b00; m_axi_rlast = 1;
        end else r_cnt++;
      end
      m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_delay);
      if (m_axi_arvalid && !m_axi_arready) ar_cnt++;
      ar_hs = m_axi_arvalid && m_axi_arready;
      if (ar_hs) begin
        ar_cnt = 0; ar_count++; last_araddr = m_axi_araddr; last_arlen = m_axi_arlen;
        last_arsize = m_axi_arsize; last_arburst = m_axi_arburst;
      end
      if (m_axi_awvalid) begin
        awv_cycles++;
        if (!aw_stalling) begin aw_first = m_axi_awaddr; aw_stalling = 1; end
        else if (m_axi_awaddr !== aw_first) stab_err++;
      end
      m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
      if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
      aw_hs = m_axi_awvalid && m_axi_awready;
      if (aw_hs) begin
        aw_cnt = 0; aw_stalling = 0; aw_count++; wr_addr = m_axi_awaddr;
        last_awaddr = m_axi_awaddr; last_awlen = m_axi_awlen;
        last_awsize = m_axi_awsize; last_awburst = m_axi_awburst;
      end
      if (m_axi_wvalid) wv_cycles++;
      m_axi_wready = m_axi_wvalid && (w_cnt >= w_delay);
      if (m_axi_wvalid && !m_axi_wready) w_cnt++;
      w_hs = m_axi_wvalid && m_axi_wready;
      if (w_hs) begin
        w_cnt = 0; w_count++; wr_data = m_axi_wdata; wr_strb = m_axi_wstrb;
        last_wstrb = m_axi_wstrb; last_wlast = m_axi_wlast;
      end
      r_hs = m_axi_rvalid && m_axi_rready;
      b_hs = m_axi_bvalid && m_axi_bready;
      if (b_hs) b_count++;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [127:0] data; logic err; } fill_exp_t;
  fill_exp_t exp_fill_q[$];
  logic      exp_wb_q[$];
  fill_exp_t fe;
  logic      we;
  int fill_done_count = 0, fill_done_cyc = -1, wb_done_cyc = -1, accept_cyc = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        fill_done_count++; fill_done_cyc = cyc;
        $display("fill_done data=%h err=%0b", fill_data, err);
        if (exp_fill_q.size() == 0) check("fill_done_unexpected", fill_done, 0);
        else begin
          fe = exp_fill_q.pop_front();
          check("fill_data", fill_data, fe.data);
          check("fill_err", err, fe.err);
        end
      end
      if (wb_done) begin
        wb_done_cyc = cyc;
        $display("wb_done err=%0b", err);
        if (exp_wb_q.size() == 0) check("wb_done_unexpected", wb_done, 0);
        else begin
          we = exp_wb_q.pop_front();
          check("wb_err", err, we);
        end
      end
      if (err && !fill_done && !wb_done) check("err_stray", err, 0);
    end
  end

  // ---------------- cache-side drivers ----------------
  task automatic fill_req(input logic [31:0] addr, input logic [127:0] exp_data, input logic exp_err);
    bit ok;
    fe.data = exp_data; fe.err = exp_err;
    exp_fill_q.push_back(fe);
    $display("fill req addr=%h", addr);
    @(negedge clk);
    fill_valid = 1; fill_addr = addr; ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (fill_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("fill_accept_timeout", ok, 1);
    accept_cyc = cyc;
    @(negedge clk);
    fill_valid = 0; fill_addr = 32'hFFFF_FFFF;
  endtask

  task automatic wb_req(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] strb);
    bit ok;
    exp_wb_q.push_back(1'b0);
    $display("wb req addr=%h strb=%h", addr, strb);
    @(negedge clk);
    wb_valid = 1; wb_addr = addr; wb_data = data; wb_strb = strb; ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (wb_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("wb_accept_timeout", ok, 1);
    @(negedge clk);
    // scramble inputs: the port must work from its latched copy
    wb_valid = 0; wb_addr = 32'hFFFF_FFF0; wb_data = '1; wb_strb = '1;
  endtask

  task automatic wait_idle();
    bit timed_out;
    timed_out = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_fill_q.size() == 0 && exp_wb_q.size() == 0 && fill_ready) begin
        timed_out = 0; break;
      end
    end
    check("idle_timeout", timed_out, 0);
  endtask

  localparam logic [127:0] LINE_100 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001;
  localparam logic [127:0] WB_DATA1 = 128'hAFAE_ADAC_ABAA_A9A8_A7A6_A5A4_A3A2_A1A0;
  localparam logic [127:0] WB_EXP1  = 128'h1111_1111_1111_1111_A7A6_A5A4_1111_1111;
  localparam logic [127:0] D2       = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D4       = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_3C3C_C3C3;
  localparam logic [127:0] LINE_300 = 128'h0000_0000_0000_0000_0000_0000_0000_CAFE;

  int base, b_before, fd_before;
  bit ok;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h100] = LINE_100;
    mem[10'h101] = {16{8'h11}};
    mem[10'h300] = LINE_300;

    repeat (3) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("rst_fill_ready", fill_ready, 1);
    check("rst_wb_ready", wb_ready, 1);
    check("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
    check("rst_done_err", {fill_done, wb_done, err}, 3'b0);
    check("rst_fill_data", fill_data, 128'h0);

    // plain fill, unaligned request address
    base = ar_count;
    fill_req(32'h0000_1004, LINE_100, 1'b0);
    wait_idle();
    check("fill_araddr", last_araddr, 32'h0000_1000);
    check("fill_arlen", last_arlen, 8'd0);
    check("fill_arsize", last_arsize, 3'd4);
    check("fill_arburst", last_arburst, 2'b01);
    check("fill_ar_count", ar_count - base, 1);
    check("fill_latency", fill_done_cyc - accept_cyc, 3);

    // partial-strobe writeback
    base = aw_count; b_before = b_count;
    wb_req(32'h0000_1010, WB_DATA1, 16'h00F0);
    wait_idle();
    check("wb_awaddr", last_awaddr, 32'h0000_1010);
    check("wb_awlen", last_awlen, 8'd0);
    check("wb_awsize", last_awsize, 3'd4);
    check("wb_awburst", last_awburst, 2'b01);
    check("wb_wlast", last_wlast, 1'b1);
    check("wb_wstrb", last_wstrb, 16'h00F0);
    check("wb_aw_count", aw_count - base, 1);
    check("wb_b_count", b_count - b_before, 1);
    check("wb_mem_line", mem[10'h101], WB_EXP1);

    // simultaneous requests: writeback wins, fill sees the new line
    exp_wb_q.push_back(1'b0);
    fe.data = D2; fe.err = 1'b0; exp_fill_q.push_back(fe);
    $display("sim req wb addr=00002000 fill addr=00002008");
    @(negedge clk);
    wb_valid = 1; wb_addr = 32'h0000_2000; wb_data = D2; wb_strb = 16'hFFFF;
    fill_valid = 1; fill_addr = 32'h0000_2008;
    check("sim_both_ready", {fill_ready, wb_ready}, 2'b11);
    @(negedge clk);
    wb_valid = 0;
    check("sim_fill_held_off", fill_ready, 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (fill_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("sim_fill_accept", ok, 1);
    @(negedge clk);
    fill_valid = 0;
    wait_idle();
    check("sim_wb_first", (wb_done_cyc < fill_done_cyc), 1);

    // AW stalled three cycles, W accepted at once
    aw_delay = 3; awv_cycles = 0; wv_cycles = 0; stab_err = 0; b_before = b_count;
    wb_req(32'h0000_4000, D4, 16'hFFFF);
    wait_idle();
    repeat (4) @(negedge clk);
    check("stall_awvalid_cycles", awv_cycles, 4);
    check("stall_wvalid_cycles", wv_cycles, 1);
    check("stall_awaddr_stable", stab_err, 0);
    check("stall_b_count", b_count - b_before, 1);
    check("stall_awaddr", last_awaddr, 32'h0000_4000);
    aw_delay = 0;
    fill_req(32'h0000_4000, D4, 1'b0);
    wait_idle();

    // SLVERR on read
    rresp_err = 1;
    fill_req(32'h0000_3000, LINE_300, 1'b1);
    wait_idle();
    rresp_err = 0;
    check("err_back_idle", fill_ready, 1);

    // reset while waiting in RD_DATA
    r_delay = 30;
    $display("fill req addr=00005000 (abandoned by reset)");
    @(negedge clk);
    fill_valid = 1; fill_addr = 32'h0000_5000;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (fill_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    fill_valid = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_axi_rready) break;
      @(negedge clk);
    end
    check("rst_reached_rd_data", m_axi_rready, 1);
    fd_before = fill_done_count;
    #2 rst = 1;
    @(negedge clk);
    #2 rst = 0;
    #1;
    check("midrst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
    check("midrst_fill_ready", fill_ready, 1);
    check("midrst_fill_done", fill_done, 0);
    r_delay = 0;
    repeat (40) @(negedge clk);
    check("midrst_no_fill_done", fill_done_count, fd_before);

    // recovery after reset
    fill_req(32'h0000_1000, LINE_100, 1'b0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
